data_memory_bytelane: RTL

//  Word-organised data memory for the single-cycle datapath, successor to the 64-word RAM.

---
 rtl/data_memory_bytelane_pkg.sv | 49 ++++
 rtl/data_memory_bytelane_load_align.sv | 43 ++++
 rtl/data_memory_bytelane.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/data_memory_bytelane_pkg.sv
// Shared encodings, FSM state type and lane helpers for the byte-lane data memory.
package data_memory_bytelane_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // True when the access size is illegal or the low address bits break its alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Bit mask of the lanes a store of this size touches at this byte offset.
    function automatic logic [31:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [31:0] m;
        case (size)
            SZ_BYTE: m = 32'h0000_00FF << {lo, 3'b000};
            SZ_HALF: m = lo[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            SZ_WORD: m = 32'hFFFF_FFFF;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    // Copy the right-justified store datum into every lane it could occupy.
    function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {4{data[7:0]}};
            SZ_HALF: r = {2{data[15:0]}};
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_memory_bytelane_load_align.sv
// Extracts the addressed byte/half/word lane from a memory word and extends it.
module data_memory_bytelane_load_align
    import data_memory_bytelane_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    output logic [31:0] o_ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the lane and extend it to 32 bits; word accesses ignore sign_ext.
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        o_ext  = 32'h0000_0000;
        case (i_size)
            SZ_BYTE: begin
                case (i_addr)
                    2'b00:   w_byte = i_word[7:0];
                    2'b01:   w_byte = i_word[15:8];
                    2'b10:   w_byte = i_word[23:16];
                    default: w_byte = i_word[31:24];
                endcase
                o_ext = {{24{i_sign_ext & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                if (i_addr[1]) begin
                    w_half = i_word[31:16];
                end else begin
                    w_half = i_word[15:0];
                end
                o_ext = {{16{i_sign_ext & w_half[15]}}, w_half};
            end
            SZ_WORD: o_ext = i_word;
            default: o_ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/data_memory_bytelane.sv
// Word-organised data memory with byte/half/word lanes, registered loads,
// misalignment flagging and a zeroing sweep after reset.
module data_memory_bytelane
    import data_memory_bytelane_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       write_data,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [31:0]       read_data,
    output logic              read_valid,
    output logic              busy,
    output logic              err
);

    localparam int            WI       = ADDR_W - 2;
    localparam int            DEPTH    = 2 ** WI;
    localparam logic [WI-1:0] LAST_IDX = {WI{1'b1}};
    localparam logic [WI-1:0] ONE_IDX  = {{(WI-1){1'b0}}, 1'b1};

    logic [31:0]   r_mem [DEPTH];
    state_t        r_state;
    state_t        w_state_nxt;
    logic [WI-1:0] r_clr_ptr;
    logic [31:0]   r_read_data;
    logic          r_read_valid;
    logic          r_err;

    logic [WI-1:0] w_idx;
    logic [31:0]   w_old_word;
    logic          w_busy;
    logic          w_bad;
    logic          w_do_load;
    logic          w_do_store;
    logic          w_err_nxt;
    logic [31:0]   w_mask;
    logic [31:0]   w_merged;
    logic [31:0]   w_ext;
    logic          w_we;
    logic [WI-1:0] w_widx;
    logic [31:0]   w_wword;

    assign w_idx      = addr[ADDR_W-1:2];
    assign w_old_word = r_mem[w_idx];
    assign w_busy     = (r_state == ST_CLEAR);
    assign w_bad      = is_misaligned(size, addr[1:0]);
    // Requests during reset or the sweep are dropped entirely.
    assign w_do_load  = !reset && !w_busy && MemRead && !w_bad;
    assign w_do_store = !reset && !w_busy && MemWrite && !w_bad;
    assign w_err_nxt  = !w_busy && (MemRead || MemWrite) && w_bad;
    assign w_mask     = lane_mask(size, addr[1:0]);
    assign w_merged   = (w_old_word & ~w_mask) | (lane_replicate(size, write_data) & w_mask);

    // Read path sees the pre-edge word, so a same-cycle store yields old data.
    data_memory_bytelane_load_align u_load_align (
        .i_word     (w_old_word),
        .i_addr     (addr[1:0]),
        .i_size     (size),
        .i_sign_ext (sign_ext),
        .o_ext      (w_ext)
    );

    // Arbitrate the single write port between the clear sweep and stores.
    always_comb begin
        w_we    = 1'b0;
        w_widx  = w_idx;
        w_wword = w_merged;
        if (reset) begin
            w_we = 1'b0;
        end else if (w_busy) begin
            w_we    = CLEAR_ON_RESET;
            w_widx  = r_clr_ptr;
            w_wword = 32'h0000_0000;
        end else begin
            w_we = w_do_store;
        end
    end

    // Memory array write port; contents are not reset, the sweep zeroes them.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_widx] <= w_wword;
        end
    end

    // Sweep leaves CLEAR after the last word, or at once when sweeping is disabled.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: begin
                if (!CLEAR_ON_RESET || (r_clr_ptr == LAST_IDX)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_IDLE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    // State register and clear pointer; reset restarts the sweep from word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= {WI{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_busy) begin
                r_clr_ptr <= r_clr_ptr + ONE_IDX;
            end else begin
                r_clr_ptr <= r_clr_ptr;
            end
        end
    end

    // Registered load result, valid strobe and error strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_data  <= 32'h0000_0000;
            r_read_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_read_valid <= w_do_load;
            r_err        <= w_err_nxt;
            if (w_do_load) begin
                r_read_data <= w_ext;
            end else begin
                r_read_data <= r_read_data;
            end
        end
    end

    assign read_data  = r_read_data;
    assign read_valid = r_read_valid;
    assign err        = r_err;
    assign busy       = w_busy;

endmodule
